// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: operand widths, ALU class/op codes,
// memory-op codes and the divider state encoding.
package ex_stage_pkg;

  localparam int WORD_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int MEM_OP_BUS   = 4;
  localparam int ALU_SEL_BUS  = 3;
  localparam int ALU_OP_BUS   = 5;

  localparam logic [ALU_SEL_BUS-1:0] ALU_NOP   = 3'd0;
  localparam logic [ALU_SEL_BUS-1:0] ALU_LOGIC = 3'd1;
  localparam logic [ALU_SEL_BUS-1:0] ALU_SHIFT = 3'd2;
  localparam logic [ALU_SEL_BUS-1:0] ALU_ARITH = 3'd3;
  localparam logic [ALU_SEL_BUS-1:0] ALU_DIV   = 3'd4;

  localparam logic [ALU_OP_BUS-1:0] ALUOP_AND  = 5'd0;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_OR   = 5'd1;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_XOR  = 5'd2;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_NOR  = 5'd3;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_LUI  = 5'd4;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SLL  = 5'd5;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SRL  = 5'd6;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SRA  = 5'd7;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_ADD  = 5'd8;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SUB  = 5'd9;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SLT  = 5'd10;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_SLTU = 5'd11;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_DIV  = 5'd12;
  localparam logic [ALU_OP_BUS-1:0] ALUOP_DIVU = 5'd13;

  localparam logic [MEM_OP_BUS-1:0] MEM_OP_NOP = 4'd0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic [WORD_BUS-1:0] neg_if(input logic neg, input logic [WORD_BUS-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: IDLE latches operand magnitudes, BUSY produces one
// quotient bit per cycle for 32 cycles, DONE presents the sign-corrected result once.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start,
  input  logic                is_signed,
  input  logic [WORD_BUS-1:0] dividend,
  input  logic [WORD_BUS-1:0] divisor,
  output logic                stall_req,
  output logic                hilo_we,
  output logic [WORD_BUS-1:0] hilo_hi,
  output logic [WORD_BUS-1:0] hilo_lo
);

  div_state_t          state_reg, state_next;
  logic [5:0]          cnt_reg;
  logic [WORD_BUS-1:0] q_reg, r_reg, d_reg;
  logic                q_neg_reg, r_neg_reg, dvz_reg;
  logic [WORD_BUS:0]   shifted;
  logic [WORD_BUS-1:0] sub;
  logic                take;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= DIV_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall_req  = 1'b0;
    hilo_we    = 1'b0;
    case (state_reg)
      DIV_IDLE: begin
        stall_req = start;
        if (start) state_next = DIV_BUSY;
      end
      DIV_BUSY: begin
        stall_req = 1'b1;
        if (cnt_reg == 6'd31) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        hilo_we    = 1'b1;
        state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
    // flush or reset cancels everything in the same cycle
    if (flush || rst) begin
      state_next = DIV_IDLE;
      stall_req  = 1'b0;
      hilo_we    = 1'b0;
    end
  end

  // The remainder stays below the divisor, so a passing trial fits in 32 bits.
  assign shifted = {r_reg, q_reg[WORD_BUS-1]};
  assign take    = (shifted >= {1'b0, d_reg});
  assign sub     = shifted[WORD_BUS-1:0] - d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= 6'd0;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      dvz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          cnt_reg <= 6'd0;
          if (start && !flush) begin
            q_reg     <= neg_if(is_signed & dividend[WORD_BUS-1], dividend);
            d_reg     <= neg_if(is_signed & divisor[WORD_BUS-1], divisor);
            r_reg     <= '0;
            q_neg_reg <= is_signed & (dividend[WORD_BUS-1] ^ divisor[WORD_BUS-1]);
            r_neg_reg <= is_signed & dividend[WORD_BUS-1];
            dvz_reg   <= (divisor == '0);
          end
        end
        DIV_BUSY: begin
          cnt_reg <= cnt_reg + 6'd1;
          r_reg   <= take ? sub : shifted[WORD_BUS-1:0];
          q_reg   <= {q_reg[WORD_BUS-2:0], take};
        end
        default: cnt_reg <= 6'd0;
      endcase
    end
  end

  // A zero divisor leaves the dividend magnitude in r_reg, so HI comes back as the dividend.
  assign hilo_hi = hilo_we ? neg_if(r_neg_reg, r_reg) : '0;
  assign hilo_lo = hilo_we ? (dvz_reg ? '1 : neg_if(q_neg_reg, q_reg)) : '0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational LOGIC/SHIFT/ARITH datapath, address generation and
// pass-through of memory/writeback control, plus the multi-cycle divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [ALU_SEL_BUS-1:0]  ex_alusel,
  input  logic [ALU_OP_BUS-1:0]   ex_aluop,
  input  logic [WORD_BUS-1:0]     ex_srcLeft,
  input  logic [WORD_BUS-1:0]     ex_srcRight,
  input  logic [WORD_BUS-1:0]     ex_offset,
  input  logic [MEM_OP_BUS-1:0]   ex_memop,
  input  logic [REG_ADDR_BUS-1:0] ex_dest,
  input  logic                    ex_writeEnable,
  output logic [WORD_BUS-1:0]     mem_result,
  output logic [WORD_BUS-1:0]     mem_addr,
  output logic [WORD_BUS-1:0]     mem_storeData,
  output logic [MEM_OP_BUS-1:0]   mem_memop,
  output logic [REG_ADDR_BUS-1:0] mem_dest,
  output logic                    mem_writeEnable,
  output logic                    hilo_we,
  output logic [WORD_BUS-1:0]     hilo_hi,
  output logic [WORD_BUS-1:0]     hilo_lo,
  output logic                    stall_req
);

  logic [WORD_BUS-1:0] alu_res;
  logic                alu_valid;
  logic                is_div;
  logic [4:0]          shamt;
  logic [WORD_BUS-1:0] logic_res;
  logic                sel_and, sel_or, sel_xor, sel_nor;

  assign is_div  = (ex_alusel == ALU_DIV);
  assign shamt   = ex_srcRight[4:0];
  assign sel_and = (ex_aluop == ALUOP_AND);
  assign sel_or  = (ex_aluop == ALUOP_OR);
  assign sel_xor = (ex_aluop == ALUOP_XOR);
  assign sel_nor = (ex_aluop == ALUOP_NOR);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BUS; gi++) begin : g_logic
      assign logic_res[gi] = (sel_and & (ex_srcLeft[gi] & ex_srcRight[gi]))
                           | (sel_or  & (ex_srcLeft[gi] | ex_srcRight[gi]))
                           | (sel_xor & (ex_srcLeft[gi] ^ ex_srcRight[gi]))
                           | (sel_nor & ~(ex_srcLeft[gi] | ex_srcRight[gi]));
    end
  endgenerate

  div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (is_div),
    .is_signed (ex_aluop == ALUOP_DIV),
    .dividend  (ex_srcLeft),
    .divisor   (ex_srcRight),
    .stall_req (stall_req),
    .hilo_we   (hilo_we),
    .hilo_hi   (hilo_hi),
    .hilo_lo   (hilo_lo)
  );

  always_comb begin
    alu_res   = '0;
    alu_valid = 1'b1;
    case (ex_alusel)
      ALU_NOP: alu_res = '0;
      ALU_LOGIC: begin
        if (ex_aluop == ALUOP_LUI)                 alu_res = {ex_srcRight[15:0], 16'h0000};
        else if (sel_and | sel_or | sel_xor | sel_nor) alu_res = logic_res;
        else                                       alu_valid = 1'b0;
      end
      ALU_SHIFT: begin
        case (ex_aluop)
          ALUOP_SLL: alu_res = ex_srcLeft << shamt;
          ALUOP_SRL: alu_res = ex_srcLeft >> shamt;
          ALUOP_SRA: alu_res = $unsigned($signed(ex_srcLeft) >>> shamt);
          default:   alu_valid = 1'b0;
        endcase
      end
      ALU_ARITH: begin
        case (ex_aluop)
          ALUOP_ADD:  alu_res = ex_srcLeft + ex_srcRight;
          ALUOP_SUB:  alu_res = ex_srcLeft - ex_srcRight;
          ALUOP_SLT:  alu_res = {31'd0, $signed(ex_srcLeft) < $signed(ex_srcRight)};
          ALUOP_SLTU: alu_res = {31'd0, ex_srcLeft < ex_srcRight};
          default:    alu_valid = 1'b0;
        endcase
      end
      ALU_DIV: alu_res = '0;
      default: alu_valid = 1'b0;
    endcase
  end

  // Reset and flush turn the stage into a NOP; a divide never writes the register file.
  always_comb begin
    mem_result      = '0;
    mem_addr        = '0;
    mem_storeData   = '0;
    mem_memop       = MEM_OP_NOP;
    mem_dest        = '0;
    mem_writeEnable = 1'b0;
    if (!rst && !flush) begin
      mem_result      = alu_res;
      mem_addr        = ex_srcLeft + ex_offset;
      mem_storeData   = ex_srcRight;
      mem_memop       = is_div ? MEM_OP_NOP : ex_memop;
      mem_dest        = ex_dest;
      mem_writeEnable = ex_writeEnable & alu_valid & ~is_div;
    end
  end

endmodule
